// File: rtl/i2c_master_txn_seq_if.sv
// Host-request / byte-controller bundle for the I2C transaction sequencer.
// master = sequencer side, slave = host + byte controller side.
interface i2c_master_txn_seq_if;
   logic       req;
   logic       req_rw;
   logic [6:0] req_dev;
   logic [7:0] req_reg;
   logic [7:0] req_wdata;
   logic       busy;
   logic       done;
   logic [1:0] status;
   logic [7:0] rd_data;
   logic       cmd_start;
   logic       cmd_stop;
   logic       cmd_read;
   logic       cmd_write;
   logic       cmd_txack;
   logic [7:0] tx_byte;
   logic       cmd_done;
   logic       cmd_rxack;
   logic       cmd_al;
   logic [7:0] rx_byte;

   modport master (
      input  req, req_rw, req_dev, req_reg, req_wdata,
      input  cmd_done, cmd_rxack, cmd_al, rx_byte,
      output busy, done, status, rd_data,
      output cmd_start, cmd_stop, cmd_read, cmd_write, cmd_txack, tx_byte
   );

   modport slave (
      output req, req_rw, req_dev, req_reg, req_wdata,
      output cmd_done, cmd_rxack, cmd_al, rx_byte,
      input  busy, done, status, rd_data,
      input  cmd_start, cmd_stop, cmd_read, cmd_write, cmd_txack, tx_byte
   );
endinterface

// File: rtl/i2c_master_txn_seq.sv
// Single-register I2C write/read sequencer driving the byte controller.
// Optional per-command watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_master_txn_seq #(
   parameter int TIMEOUT_W = 16,
   parameter int NBITS     = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   i2c_master_txn_seq_if.master bus
);
   typedef enum logic [NBITS-1:0] {
      S_IDLE, S_DEV_W, S_REG, S_WDATA, S_RSTART, S_RDATA, S_ERR_STOP, S_FIN
   } state_t;

   localparam logic [1:0] ST_OK   = 2'b00;
   localparam logic [1:0] ST_NACK = 2'b01;
   localparam logic [1:0] ST_AL   = 2'b10;
`ifdef I2C_SEQ_TIMEOUT_EN
   localparam logic [1:0] ST_TO   = 2'b11;
`endif

   state_t     state_q, state_d;
   logic       issued_q, issued_d;
   logic       rw_q, rw_d;
   logic [6:0] dev_q, dev_d;
   logic [7:0] reg_q, reg_d;
   logic [7:0] wdata_q, wdata_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [1:0] status_q, status_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       start_q, start_d, stop_q, stop_d, read_q, read_d;
   logic       write_q, write_d, txack_q, txack_d;
   logic [7:0] tx_byte_q, tx_byte_d;
   logic       go_fin, clr_cmd;
`ifdef I2C_SEQ_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
`endif

   // Each active state takes one cycle to issue its command (issued_q=0),
   // then waits for cmd_done; this yields the idle gap between commands.
   always_comb begin
      state_d   = state_q;
      issued_d  = issued_q;
      rw_d      = rw_q;
      dev_d     = dev_q;
      reg_d     = reg_q;
      wdata_d   = wdata_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      status_d  = status_q;
      rd_data_d = rd_data_q;
      start_d   = start_q;
      stop_d    = stop_q;
      read_d    = read_q;
      write_d   = write_q;
      txack_d   = txack_q;
      tx_byte_d = tx_byte_q;
      go_fin    = 1'b0;
      clr_cmd   = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      case (state_q)
         S_IDLE: if (bus.req) begin
            rw_d     = bus.req_rw;
            dev_d    = bus.req_dev;
            reg_d    = bus.req_reg;
            wdata_d  = bus.req_wdata;
            status_d = ST_OK;
            busy_d   = 1'b1;
            issued_d = 1'b0;
            state_d  = S_DEV_W;
         end
         S_FIN: state_d = S_IDLE;
         S_DEV_W, S_REG, S_WDATA, S_RSTART, S_RDATA, S_ERR_STOP: begin
            if (bus.cmd_al) begin
               // Bus lost: no STOP may be driven.
               clr_cmd  = 1'b1;
               status_d = ST_AL;
               go_fin   = 1'b1;
            end else if (!issued_q) begin
               issued_d = 1'b1;
`ifdef I2C_SEQ_TIMEOUT_EN
               cnt_d    = '0;
`endif
               case (state_q)
                  S_DEV_W:    begin start_d = 1'b1; write_d = 1'b1; tx_byte_d = {dev_q, 1'b0}; end
                  S_REG:      begin write_d = 1'b1; tx_byte_d = reg_q; end
                  S_WDATA:    begin write_d = 1'b1; stop_d = 1'b1; tx_byte_d = wdata_q; end
                  S_RSTART:   begin start_d = 1'b1; write_d = 1'b1; tx_byte_d = {dev_q, 1'b1}; end
                  S_RDATA:    begin read_d = 1'b1; stop_d = 1'b1; txack_d = 1'b1; end
                  S_ERR_STOP: stop_d = 1'b1;
                  default:    ;
               endcase
            end else if (bus.cmd_done) begin
               clr_cmd  = 1'b1;
               issued_d = 1'b0;
               case (state_q)
                  S_DEV_W:  state_d = bus.cmd_rxack ? S_ERR_STOP : S_REG;
                  S_REG:    state_d = bus.cmd_rxack ? S_ERR_STOP : (rw_q ? S_RSTART : S_WDATA);
                  S_WDATA:  begin status_d = bus.cmd_rxack ? ST_NACK : ST_OK; go_fin = 1'b1; end
                  S_RSTART: state_d = bus.cmd_rxack ? S_ERR_STOP : S_RDATA;
                  S_RDATA:  begin rd_data_d = bus.rx_byte; status_d = ST_OK; go_fin = 1'b1; end
                  S_ERR_STOP: begin status_d = ST_NACK; go_fin = 1'b1; end
                  default:  ;
               endcase
            end
`ifdef I2C_SEQ_TIMEOUT_EN
            else if (&cnt_q) begin
               clr_cmd  = 1'b1;
               status_d = ST_TO;
               go_fin   = 1'b1;
            end else begin
               // Leaving on all-ones means the counter can never wrap.
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
      if (clr_cmd) begin
         start_d = 1'b0;
         stop_d  = 1'b0;
         read_d  = 1'b0;
         write_d = 1'b0;
         txack_d = 1'b0;
      end
      if (go_fin) begin
         state_d  = S_FIN;
         done_d   = 1'b1;
         busy_d   = 1'b0;
         issued_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         issued_q  <= 1'b0;
         rw_q      <= 1'b0;
         dev_q     <= '0;
         reg_q     <= '0;
         wdata_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         status_q  <= '0;
         rd_data_q <= '0;
         start_q   <= 1'b0;
         stop_q    <= 1'b0;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         txack_q   <= 1'b0;
         tx_byte_q <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         issued_q  <= issued_d;
         rw_q      <= rw_d;
         dev_q     <= dev_d;
         reg_q     <= reg_d;
         wdata_q   <= wdata_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         status_q  <= status_d;
         rd_data_q <= rd_data_d;
         start_q   <= start_d;
         stop_q    <= stop_d;
         read_q    <= read_d;
         write_q   <= write_d;
         txack_q   <= txack_d;
         tx_byte_q <= tx_byte_d;
`ifdef I2C_SEQ_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.status    = status_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.cmd_start = start_q;
   assign bus.cmd_stop  = stop_q;
   assign bus.cmd_read  = read_q;
   assign bus.cmd_write = write_q;
   assign bus.cmd_txack = txack_q;
   assign bus.tx_byte   = tx_byte_q;
endmodule

// File: doc/i2c_master_txn_seq.md
Name: i2c_master_txn_seq

Overview:
Transaction sequencer for the I2C master byte controller. It turns one host request into the full byte-command sequence for a single-register write or read, using 7-bit device address, 8-bit register address and 8-bit data. It sits between the host register file and the byte controller. It issues Start/Stop/Read/Write/Tx_ack and the transmit byte, checks slave ACKs and arbitration loss, and returns read data and a status code.

Parameters:
TIMEOUT_W, 16, width of the per-command watchdog counter (used only with the optional feature)
NBITS, 4, width of the state register

Ports:
Clk          in   1  master clock
Rst_n        in   1  asynchronous active-low reset
Req          in   1  start a transaction; sampled only in IDLE
Req_rw       in   1  0 = register write, 1 = register read
Req_dev      in   7  slave device address
Req_reg      in   8  register address
Req_wdata    in   8  write data
Busy         out  1  transaction in progress
Done         out  1  one-cycle pulse at transaction end
Status       out  2  00 OK, 01 NACK, 10 arbitration lost, 11 timeout
Rd_data      out  8  byte read from the slave; valid when Done is high and Status is 00
Cmd_start    out  1  to byte ctrl Start
Cmd_stop     out  1  to byte ctrl Stop
Cmd_read     out  1  to byte ctrl Read
Cmd_write    out  1  to byte ctrl Write
Cmd_txack    out  1  to byte ctrl Tx_ack (1 = NACK)
Tx_byte      out  8  byte loaded into the shift register
Cmd_done     in   1  byte ctrl I2C_done pulse
Cmd_rxack    in   1  byte ctrl Rx_ack (1 = slave NACK)
Cmd_al       in   1  byte ctrl I2C_al
Rx_byte      in   8  shift register contents after a read

Behaviour:
- Reset value of every output is 0 (Busy, Done, Status, Rd_data, all Cmd_*, Tx_byte). Request latches are also cleared.
- Req accepted in IDLE only; Req during Busy is ignored.
- On accept: latch Req_rw, Req_dev, Req_reg, Req_wdata; Busy goes to 1 the next cycle.
- Command handshake:
  - Cmd_* and Tx_byte are registered and held stable until the cycle Cmd_done = 1.
  - All Cmd_* are cleared in the cycle after Cmd_done, giving at least one idle cycle between commands.
  - Cmd_rxack and Rx_byte are sampled in the Cmd_done cycle.
- States and transitions (each transition happens on Cmd_done unless noted):
  - IDLE: on Req goes to DEV_W.
  - DEV_W: Start+Write, Tx_byte = {dev,0}. ACK goes to REG; NACK goes to ERR_STOP.
  - REG: Write, Tx_byte = reg. ACK goes to WDATA if rw = 0, else RSTART; NACK goes to ERR_STOP.
  - WDATA: Write+Stop, Tx_byte = wdata. Goes to FIN with Status = NACK if NACK, else OK.
  - RSTART: Start+Write, Tx_byte = {dev,1} (repeated start). ACK goes to RDATA; NACK goes to ERR_STOP.
  - RDATA: Read+Stop, Cmd_txack = 1 (master NACKs the last byte). Rd_data <= Rx_byte; goes to FIN with Status OK.
  - ERR_STOP: Stop alone. Goes to FIN with Status NACK.
  - FIN: Done = 1 for one cycle, Busy = 0. Goes to IDLE unconditionally.
- Cmd_al = 1 in any non-IDLE state has priority over Cmd_done:
  - clear all Cmd_* immediately;
  - Status = 10, go to FIN;
  - no STOP is issued because the bus is lost.
- Status holds its value until the next accepted Req, which clears it to 00.
- Rd_data holds its value until the next successful read.
- Asynchronous reset mid-transaction forces IDLE with all outputs at 0. No STOP is issued.

Optional Feature:
- Macro I2C_SEQ_TIMEOUT_EN.
- When defined:
  - a TIMEOUT_W-bit counter clears on every command issue and increments each cycle while waiting for Cmd_done;
  - on all-ones: clear Cmd_*, Status = 11, go to FIN.
  - The counter saturates and never wraps.
- When undefined: no counter exists, Status 11 is never produced, and the sequencer waits indefinitely.

Test Plan:
- Write dev=0x50, reg=0x10, wdata=0xA5, all ACK -> byte-ctrl sees Start+Write 0xA0, Write 0x10, Write+Stop 0xA5; Done pulses once; Status=00; Busy high throughout.
- Read dev=0x50, reg=0x22, model returns Rx_byte=0x3C -> commands Start+Write 0xA0, Write 0x22, Start+Write 0xA1, Read+Stop with Cmd_txack=1; Rd_data=0x3C; Status=00.
- Write with Cmd_rxack=1 on the device byte -> next command is Stop alone; Status=01; REG byte never issued.
- Cmd_al=1 asserted during REG, in the same cycle as Cmd_done -> arbitration wins; all Cmd_* are 0 the next cycle; Status=10; no Stop issued.
- Req pulsed while Busy, then Rst_n low mid-RDATA -> second Req is ignored; after reset all outputs are 0 and the state is IDLE; a new Req then completes normally.
- With I2C_SEQ_TIMEOUT_EN defined and TIMEOUT_W=4, Cmd_done is never returned -> after 15 cycles Status=11, Done pulses, Cmd_* are cleared.
